// File: rtl/mips16_defs.sv
// rtl/mips16_defs.sv - opcode constants, instruction field positions and decode helpers for the mips16 decode stage
package mips16_defs;

    localparam int RF_AW_DEFAULT = 4;

    localparam int OPC_LSB = 28;
    localparam int RD_LSB  = 24;
    localparam int RS_LSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_NOP       = 4'h0;
    localparam logic [3:0] OP_ALU_FIRST = 4'h1;
    localparam logic [3:0] OP_ALU_LAST  = 4'h7;
    localparam logic [3:0] OP_ADDI      = 4'h8;
    localparam logic [3:0] OP_LD        = 4'h9;
    localparam logic [3:0] OP_ST        = 4'hA;
    localparam logic [3:0] OP_JMP       = 4'hC;
    localparam logic [3:0] OP_ILL_E     = 4'hE;
    localparam logic [3:0] OP_ILL_F     = 4'hF;

    typedef struct packed {
        logic reg_we;
        logic mem_rd;
        logic mem_wr;
        logic illegal;
    } ctrl_t;

    // Reserved codes, JMP and illegal codes all leave every write enable low.
    function automatic ctrl_t decode_ctrl(input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_ADDI: c.reg_we = 1'b1;
            OP_LD: begin
                c.reg_we = 1'b1;
                c.mem_rd = 1'b1;
            end
            OP_ST: c.mem_wr = 1'b1;
            OP_ILL_E, OP_ILL_F: c.illegal = 1'b1;
            default: c.reg_we = (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
        endcase
        return c;
    endfunction

    function automatic logic reads_rs(input logic [3:0] op);
        return (op >= OP_ALU_FIRST) && (op <= OP_ST);
    endfunction

    function automatic logic reads_rt(input logic [3:0] op);
        return ((op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST)) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/instruction_decode_if.sv
// rtl/instruction_decode_if.sv - fetch-side and ID/EX signal bundle of instruction_decode; DECODE_PERF_EN adds the perf counter outputs
interface instruction_decode_if import mips16_defs::*; #(
    parameter int RF_AW = RF_AW_DEFAULT
) ();
    logic [31:0]      ins;
    logic [15:0]      current_address;
    logic             ex_ready;
    logic [15:0]      jmp_loc;
    logic             pc_mux_sel;
    logic             stall;
    logic             stall_pm;
    logic             idex_valid;
    logic [3:0]       idex_opcode;
    logic [RF_AW-1:0] idex_rd;
    logic [RF_AW-1:0] idex_rs;
    logic [RF_AW-1:0] idex_rt;
    logic [15:0]      idex_imm;
    logic [15:0]      idex_pc;
    logic             idex_reg_we;
    logic             idex_mem_rd;
    logic             idex_mem_wr;
    logic             illegal;
`ifdef DECODE_PERF_EN
    logic [15:0]      perf_stall_cnt;
    logic [15:0]      perf_flush_cnt;

    modport master (
        input  ins, current_address, ex_ready,
        output jmp_loc, pc_mux_sel, stall, stall_pm,
        output idex_valid, idex_opcode, idex_rd, idex_rs, idex_rt, idex_imm, idex_pc,
        output idex_reg_we, idex_mem_rd, idex_mem_wr, illegal,
        output perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        output ins, current_address, ex_ready,
        input  jmp_loc, pc_mux_sel, stall, stall_pm,
        input  idex_valid, idex_opcode, idex_rd, idex_rs, idex_rt, idex_imm, idex_pc,
        input  idex_reg_we, idex_mem_rd, idex_mem_wr, illegal,
        input  perf_stall_cnt, perf_flush_cnt
    );
`else
    modport master (
        input  ins, current_address, ex_ready,
        output jmp_loc, pc_mux_sel, stall, stall_pm,
        output idex_valid, idex_opcode, idex_rd, idex_rs, idex_rt, idex_imm, idex_pc,
        output idex_reg_we, idex_mem_rd, idex_mem_wr, illegal
    );

    modport slave (
        output ins, current_address, ex_ready,
        input  jmp_loc, pc_mux_sel, stall, stall_pm,
        input  idex_valid, idex_opcode, idex_rd, idex_rs, idex_rt, idex_imm, idex_pc,
        input  idex_reg_we, idex_mem_rd, idex_mem_wr, illegal
    );
`endif
endinterface

// File: rtl/instruction_decode_hazard.sv
// rtl/instruction_decode_hazard.sv - hazard_unit: combinational load-use detect and hold/squash priority
module hazard_unit import mips16_defs::*; #(
    parameter int RF_AW = RF_AW_DEFAULT
) (
    input  logic             reset,
    input  logic             ex_ready,
    input  logic             ifid_valid,
    input  logic [3:0]       ifid_opcode,
    input  logic [RF_AW-1:0] ifid_rs,
    input  logic [RF_AW-1:0] ifid_rt,
    input  logic             idex_valid,
    input  logic             idex_mem_rd,
    input  logic [RF_AW-1:0] idex_rd,
    output logic             stall,
    output logic             stall_pm,
    output logic             pc_mux_sel,
    output logic             fire,
    output logic             ifid_en,
    output logic             idex_en
);
    logic load_use;

    always_comb begin
        load_use   = 1'b0;
        stall      = 1'b0;
        stall_pm   = 1'b0;
        pc_mux_sel = 1'b0;
        fire       = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        if (reset) begin
            load_use = idex_valid && idex_mem_rd && (idex_rd != '0) && ifid_valid &&
                       ((reads_rs(ifid_opcode) && (ifid_rs == idex_rd)) ||
                        (reads_rt(ifid_opcode) && (ifid_rt == idex_rd)));
            stall      = !ex_ready || load_use;
            stall_pm   = stall;
            fire       = ifid_valid && ex_ready && !load_use;
            // A JMP held by back-pressure waits until it actually fires.
            pc_mux_sel = fire && (ifid_opcode == OP_JMP);
            ifid_en    = !stall;
            idex_en    = ex_ready;
        end
    end
endmodule

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - IF/ID capture and ID/EX decode with jump squash and load-use stall; DECODE_PERF_EN adds stall/flush counters
module instruction_decode import mips16_defs::*; #(
    parameter int RF_AW = RF_AW_DEFAULT
) (
    input logic                 clk,
    input logic                 reset,
    instruction_decode_if.master bus
);
    logic [31:0] ifid_ins;
    logic [15:0] ifid_pc;
    logic        ifid_valid;
    logic [15:0] pc_q;
    logic        fetch_live;

    logic [3:0]       ifid_opcode;
    logic [RF_AW-1:0] ifid_rd;
    logic [RF_AW-1:0] ifid_rs;
    logic [RF_AW-1:0] ifid_rt;
    logic [15:0]      ifid_imm;
    ctrl_t            ifid_ctrl;

    logic stall;
    logic pc_mux_sel;
    logic fire;
    logic ifid_en;
    logic idex_en;

    assign ifid_opcode = ifid_ins[OPC_LSB +: 4];
    assign ifid_rd     = ifid_ins[RD_LSB +: RF_AW];
    assign ifid_rs     = ifid_ins[RS_LSB +: RF_AW];
    assign ifid_rt     = ifid_ins[RT_LSB +: RF_AW];
    assign ifid_imm    = ifid_ins[IMM_LSB +: 16];
    assign ifid_ctrl   = decode_ctrl(ifid_opcode);

    hazard_unit #(.RF_AW(RF_AW)) u_hazard (
        .reset       (reset),
        .ex_ready    (bus.ex_ready),
        .ifid_valid  (ifid_valid),
        .ifid_opcode (ifid_opcode),
        .ifid_rs     (ifid_rs),
        .ifid_rt     (ifid_rt),
        .idex_valid  (bus.idex_valid),
        .idex_mem_rd (bus.idex_mem_rd),
        .idex_rd     (bus.idex_rd),
        .stall       (stall),
        .stall_pm    (bus.stall_pm),
        .pc_mux_sel  (pc_mux_sel),
        .fire        (fire),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en)
    );

    assign bus.stall      = stall;
    assign bus.pc_mux_sel = pc_mux_sel;
    assign bus.jmp_loc    = pc_mux_sel ? ifid_imm : 16'h0000;

    // pc_q tracks the address whose word is on ins; the first word after
    // reset is garbage, so fetch_live gates ifid_valid for one capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ifid_ins   <= '0;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
            pc_q       <= '0;
            fetch_live <= 1'b0;
        end else if (ifid_en) begin
            fetch_live <= 1'b1;
            pc_q       <= bus.current_address;
            if (pc_mux_sel) begin
                ifid_ins   <= {OP_NOP, 28'h0};
                ifid_valid <= 1'b0;
            end else begin
                ifid_ins   <= bus.ins;
                ifid_pc    <= pc_q;
                ifid_valid <= fetch_live;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.idex_valid  <= 1'b0;
            bus.idex_opcode <= '0;
            bus.idex_rd     <= '0;
            bus.idex_rs     <= '0;
            bus.idex_rt     <= '0;
            bus.idex_imm    <= '0;
            bus.idex_pc     <= '0;
            bus.idex_reg_we <= 1'b0;
            bus.idex_mem_rd <= 1'b0;
            bus.idex_mem_wr <= 1'b0;
            bus.illegal     <= 1'b0;
        end else if (idex_en) begin
            if (fire) begin
                bus.idex_valid  <= 1'b1;
                bus.idex_opcode <= ifid_opcode;
                bus.idex_rd     <= ifid_rd;
                bus.idex_rs     <= ifid_rs;
                bus.idex_rt     <= ifid_rt;
                bus.idex_imm    <= ifid_imm;
                bus.idex_pc     <= ifid_pc;
                bus.idex_reg_we <= ifid_ctrl.reg_we;
                bus.idex_mem_rd <= ifid_ctrl.mem_rd;
                bus.idex_mem_wr <= ifid_ctrl.mem_wr;
                bus.illegal     <= ifid_ctrl.illegal;
            end else begin
                bus.idex_valid  <= 1'b0;
                bus.idex_opcode <= '0;
                bus.idex_rd     <= '0;
                bus.idex_rs     <= '0;
                bus.idex_rt     <= '0;
                bus.idex_imm    <= '0;
                bus.idex_pc     <= '0;
                bus.idex_reg_we <= 1'b0;
                bus.idex_mem_rd <= 1'b0;
                bus.idex_mem_wr <= 1'b0;
                bus.illegal     <= 1'b0;
            end
        end else begin
            bus.illegal <= 1'b0;
        end
    end

`ifdef DECODE_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (pc_mux_sel && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

    assign bus.perf_stall_cnt = stall_cnt;
    assign bus.perf_flush_cnt = flush_cnt;
`endif

endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - directed and randomized checks of instruction_decode against a program-order model
`timescale 1ns/1ps
module tb_instruction_decode;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    instruction_decode_if #(.RF_AW(4)) bus ();
    instruction_decode #(.RF_AW(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Program memory model: one-cycle read, PC and word hold on stall.
    logic [31:0] mem [0:255];
    logic [15:0] pc_reg;
    logic [31:0] ins_reg;
    assign bus.current_address = bus.pc_mux_sel ? bus.jmp_loc : pc_reg;
    assign bus.ins = ins_reg;
    always @(posedge clk) begin
        if (!reset) begin
            pc_reg  <= 16'h0;
            ins_reg <= $urandom;
        end else begin
            if (!bus.stall) pc_reg <= bus.current_address + 16'd1;
            if (!bus.stall_pm) ins_reg <= mem[bus.current_address[7:0]];
        end
    end

    function automatic bit m_reads_rs(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd10);
    endfunction
    function automatic bit m_reads_rt(input logic [3:0] op);
        return ((op >= 4'd1) && (op <= 4'd7)) || (op == 4'd10);
    endfunction

    function automatic logic [63:0] snap();
        return {12'h0, bus.idex_valid, bus.idex_opcode, bus.idex_rd, bus.idex_rs, bus.idex_rt,
                bus.idex_imm, bus.idex_pc, bus.idex_reg_we, bus.idex_mem_rd, bus.idex_mem_wr};
    endfunction

    // Model: valid ID/EX entries must follow program order from pc 0.
    logic [15:0] model_pc = 16'h0;
    bit          ld_haz = 1'b0;
    logic [3:0]  ld_rd = 4'h0;
    bit          last_er = 1'b0;
    bit          last_rst = 1'b0;
    logic [63:0] held = '0;
    logic [63:0] cur;
    logic [31:0] mw;
    logic [3:0]  mop;
    bit          exp_haz;

    int          retire_cnt, jump_cnt, stall_obs, illegal_cnt;
    logic [15:0] last_jmp_loc;
    logic [15:0] ret_pc_q[$];
    bit          log_valid[$];
    logic [15:0] log_pc[$];
    logic [3:0]  log_rs[$];

    task automatic clear_stats();
        retire_cnt = 0; jump_cnt = 0; stall_obs = 0; illegal_cnt = 0;
        last_jmp_loc = 16'h0;
        ret_pc_q.delete(); log_valid.delete(); log_pc.delete(); log_rs.delete();
    endtask

    always @(negedge clk) begin
        cur = snap();
        if (!reset) begin
            chk("reset_comb_zero", {bus.jmp_loc, bus.pc_mux_sel, bus.stall, bus.stall_pm}, 64'h0);
            if (!last_rst) begin
                chk("reset_regs_zero", {cur[51:0], bus.illegal}, 64'h0);
`ifdef DECODE_PERF_EN
                chk("reset_perf_zero", {bus.perf_stall_cnt, bus.perf_flush_cnt}, 64'h0);
`endif
            end
            model_pc = 16'h0;
            ld_haz = 1'b0;
        end else begin
            if (last_rst) begin
                if (last_er) begin
                    log_valid.push_back(bus.idex_valid);
                    log_pc.push_back(bus.idex_pc);
                    log_rs.push_back(bus.idex_rs);
                    if (bus.idex_valid) begin
                        mw = mem[model_pc[7:0]];
                        mop = mw[31:28];
                        chk("order_pc", bus.idex_pc, model_pc);
                        chk("fields", {bus.idex_opcode, bus.idex_rd, bus.idex_rs, bus.idex_rt, bus.idex_imm}, mw);
                        chk("ctrl", {bus.idex_reg_we, bus.idex_mem_rd, bus.idex_mem_wr, bus.illegal},
                            {(mop >= 4'd1 && mop <= 4'd9), mop == 4'd9, mop == 4'd10, mop >= 4'hE});
                        ld_haz = (mop == 4'd9) && (mw[27:24] != 4'h0);
                        ld_rd = mw[27:24];
                        model_pc = (mop == 4'hC) ? mw[15:0] : model_pc + 16'd1;
                        ret_pc_q.push_back(bus.idex_pc);
                        retire_cnt++;
                        if (bus.illegal) illegal_cnt++;
                    end else begin
                        chk("bubble_no_illegal", bus.illegal, 0);
                        ld_haz = 1'b0;
                    end
                end else begin
                    chk("hold_idex", cur, held);
                    chk("hold_no_illegal", bus.illegal, 0);
                end
            end
            mw = mem[model_pc[7:0]];
            mop = mw[31:28];
            exp_haz = ld_haz && ((m_reads_rs(mop) && mw[23:20] == ld_rd) ||
                                 (m_reads_rt(mop) && mw[19:16] == ld_rd));
            chk("stall", bus.stall, !bus.ex_ready || exp_haz);
            chk("stall_pm", bus.stall_pm, !bus.ex_ready || exp_haz);
            if (bus.stall) stall_obs++;
            if (bus.pc_mux_sel) begin
                jump_cnt++;
                last_jmp_loc = bus.jmp_loc;
                chk("jump_on_jmp", {bus.ex_ready, mop}, {1'b1, 4'hC});
                chk("jmp_loc", bus.jmp_loc, mw[15:0]);
            end else begin
                chk("jmp_loc_idle", bus.jmp_loc, 0);
            end
        end
        last_er = bus.ex_ready;
        last_rst = reset;
        held = cur;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_ins();
        int k;
        logic [3:0] op;
        k = $urandom_range(0, 15);
        if (k < 3) op = 4'h9;
        else if (k < 6) op = 4'($urandom_range(1, 7));
        else if (k == 6) op = 4'h8;
        else if (k == 7) op = 4'hA;
        else if (k == 8) op = 4'hC;
        else if (k == 9) op = 4'($urandom_range(14, 15));
        else op = 4'($urandom_range(0, 15));
        if (op == 4'hC) return {op, 12'($urandom), 16'($urandom_range(0, 255))};
        return {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 16'($urandom)};
    endfunction

    int          idx;
    logic [15:0] exp_a [7];
    logic [15:0] exp_b [4];

    initial begin
        bus.ex_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]     = 32'h8100_0005; // ADDI r1,r0,5
        mem[1]     = 32'h9210_0000; // LD   r2,0(r1)
        mem[2]     = 32'h1321_0000; // ADD  r3,r2,r1
        mem[3]     = 32'hC000_0040; // JMP  0x0040
        mem[4]     = 32'h8500_0007; // squashed
        mem[8'h40] = 32'h8600_0001;
        mem[8'h42] = 32'hF000_0000; // illegal

        repeat (3) tick();
        clear_stats();
        reset = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("first_edge_idex_valid", bus.idex_valid, 0);
        tick(); tick();
        @(negedge clk);
        chk("addi_opcode", bus.idex_opcode, 8);
        chk("addi_rd", bus.idex_rd, 1);
        chk("addi_imm", bus.idex_imm, 5);
        chk("addi_pc", bus.idex_pc, 0);
        chk("addi_reg_we", {bus.idex_valid, bus.idex_reg_we}, 2'b11);
        repeat (20) tick();

        exp_a = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h40, 16'h41, 16'h42};
        for (int i = 0; i < 7; i++)
            chk("prog_a_order", (i < ret_pc_q.size()) ? ret_pc_q[i] : 16'hDEAD, exp_a[i]);
        chk("prog_a_jumps", jump_cnt, 1);
        chk("prog_a_jmp_loc", last_jmp_loc, 16'h0040);
        chk("prog_a_stall_cycles", stall_obs, 1);
        chk("prog_a_illegal_pulses", illegal_cnt, 1);
        idx = -1;
        foreach (log_pc[i]) if (idx < 0 && log_valid[i] && log_pc[i] == 16'h1) idx = i;
        if (idx >= 0 && idx + 2 < log_pc.size()) begin
            chk("ld_bubble", log_valid[idx+1], 0);
            chk("ld_then_add", {log_valid[idx+2], log_pc[idx+2], log_rs[idx+2]}, {1'b1, 16'h2, 4'h2});
        end else begin
            chk("ld_found", 0, 1);
        end
`ifdef DECODE_PERF_EN
        chk("perf_flush_a", bus.perf_flush_cnt, 1);
        chk("perf_stall_a", bus.perf_stall_cnt, 1);
`endif

        // Back-pressure with a JMP sitting in IF/ID.
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[2]     = 32'hC000_0010;
        mem[8'h10] = 32'h8700_0003;
        reset = 1'b0;
        repeat (2) tick();
        clear_stats();
        reset = 1'b1;
        repeat (4) tick();
        bus.ex_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_stall", bus.stall, 1);
            chk("bp_no_jump", bus.pc_mux_sel, 0);
            tick();
        end
        bus.ex_ready = 1'b1;
        @(negedge clk);
        chk("bp_jump_fires", {bus.pc_mux_sel, bus.jmp_loc}, {1'b1, 16'h0010});
        repeat (10) tick();
        exp_b = '{16'h0, 16'h1, 16'h2, 16'h10};
        for (int i = 0; i < 4; i++)
            chk("prog_b_order", (i < ret_pc_q.size()) ? ret_pc_q[i] : 16'hDEAD, exp_b[i]);

        // Randomized program with random back-pressure and a mid-run reset.
        for (int i = 0; i < 256; i++) mem[i] = rand_ins();
        reset = 1'b0;
        repeat (2) tick();
        clear_stats();
        reset = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            bus.ex_ready = ($urandom_range(0, 4) != 0);
            if (c == 2000) reset = 1'b0;
            if (c == 2002) reset = 1'b1;
            tick();
        end
        bus.ex_ready = 1'b1;
        chk("random_liveness", retire_cnt > 800, 1);

`ifdef DECODE_PERF_EN
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        bus.ex_ready = 1'b0;
        repeat (70000) tick();
        chk("perf_stall_saturate", bus.perf_stall_cnt, 16'hFFFF);
        bus.ex_ready = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
